// File: rtl/sport1_rx_ctl.sv
// SPORT1 receive control: frames DR into SLEN+1 bit words (MSB first), formats them
// onto RX and raises an interrupt or autobuffer request per word, with sticky overrun.
module sport1_rx_ctl #(
  parameter int WCNT_W = 8
) (
  input  logic              SCLKg5,
  input  logic              rst_SP_ENg,
  input  logic              RFSsm,
  input  logic              DR,
  input  logic [4:0]        SLEN,
  input  logic              DTYPE,
  input  logic [WCNT_W-1:0] MWORD,
  input  logic              RBUF,
  input  logic              RSack,
  output logic [15:0]       RX,
  output logic              RX_valid,
  output logic              RSreq,
  output logic              RIRQ,
  output logic              ROVF,
  output logic [3:0]        SLOT_NUM
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SHIFT  = 3'b010,
    ST_WSTART = 3'b100
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          bcnt_q, bcnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [14:0]         rxsht_q, rxsht_d;
  logic [15:0]         rx_q, rx_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rsreq_q, rsreq_d;
  logic                rirq_q, rirq_d;
  logic                rovf_q, rovf_d;
  logic                done_s;
  logic [15:0]         word_s;

  // Bits above SLEN are already zero; sign-extension replicates the data MSB into them.
  function automatic logic [15:0] fmt_word(input logic [15:0] w, input logic [4:0] slen,
                                           input logic dtype);
    logic [15:0] r;
    r = w;
    for (int i = 0; i < 16; i++) begin
      if (dtype && (i > int'(slen))) begin
        r[i] = w[slen[3:0]];
      end else begin
        r[i] = w[i];
      end
    end
    return r;
  endfunction

  // Next-state, counters, word formatting and request/overrun logic.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    rxsht_d    = rxsht_q;
    rx_d       = rx_q;
    rx_valid_d = 1'b0;
    rirq_d     = 1'b0;
    rsreq_d    = rsreq_q;
    rovf_d     = rovf_q;
    done_s     = 1'b0;
    word_s     = {rxsht_q, DR};
    case (state_q)
      ST_IDLE: begin
        if (RFSsm) begin
          state_d = ST_SHIFT;
          bcnt_d  = SLEN;
          rxsht_d = 15'h0000;
          wcnt_d  = MWORD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        rxsht_d = word_s[14:0];
        if (bcnt_q != 5'd0) begin
          bcnt_d  = bcnt_q - 5'd1;
          state_d = ST_SHIFT;
        end else begin
          done_s = 1'b1;
          if (wcnt_q == {WCNT_W{1'b0}}) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WSTART;
            wcnt_d  = wcnt_q - {{(WCNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_WSTART: begin
        state_d = ST_SHIFT;
        bcnt_d  = SLEN;
        rxsht_d = 15'h0000;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (done_s) begin
      rx_d       = fmt_word(word_s, SLEN, DTYPE);
      rx_valid_d = 1'b1;
      rirq_d     = ~RBUF;
    end else begin
      rx_d = rx_q;
    end

    // A new completion beats a same-edge acknowledge.
    if (done_s && RBUF) begin
      rsreq_d = 1'b1;
      if (rsreq_q && !RSack) begin
        rovf_d = 1'b1;
      end else begin
        rovf_d = rovf_q;
      end
    end else if (RSack && !done_s) begin
      rsreq_d = 1'b0;
    end else begin
      rsreq_d = rsreq_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge SCLKg5 or posedge rst_SP_ENg) begin
    if (rst_SP_ENg) begin
      state_q    <= ST_IDLE;
      bcnt_q     <= 5'd0;
      wcnt_q     <= {WCNT_W{1'b0}};
      rxsht_q    <= 15'h0000;
      rx_q       <= 16'h0000;
      rx_valid_q <= 1'b0;
      rsreq_q    <= 1'b0;
      rirq_q     <= 1'b0;
      rovf_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      rxsht_q    <= rxsht_d;
      rx_q       <= rx_d;
      rx_valid_q <= rx_valid_d;
      rsreq_q    <= rsreq_d;
      rirq_q     <= rirq_d;
      rovf_q     <= rovf_d;
    end
  end

  assign RX       = rx_q;
  assign RX_valid = rx_valid_q;
  assign RSreq    = rsreq_q;
  assign RIRQ     = rirq_q;
  assign ROVF     = rovf_q;
  assign SLOT_NUM = wcnt_q[3:0];

endmodule

// File: tb/tb_sport1_rx_ctl.sv
// Bench for sport1_rx_ctl: directed scenarios plus randomized frames checked every
// cycle against a word-level reference model of framing, formatting and requests.
module tb_sport1_rx_ctl;

  logic        SCLKg5 = 1'b0;
  logic        rst_SP_ENg;
  logic        RFSsm;
  logic        DR;
  logic [4:0]  SLEN;
  logic        DTYPE;
  logic [7:0]  MWORD;
  logic        RBUF;
  logic        RSack;
  logic [15:0] RX;
  logic        RX_valid;
  logic        RSreq;
  logic        RIRQ;
  logic        ROVF;
  logic [3:0]  SLOT_NUM;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_rx;
  logic        exp_rsreq;
  logic        exp_rovf;
  logic [15:0] wbuf [0:7];

  sport1_rx_ctl #(.WCNT_W(8)) dut (
    .SCLKg5(SCLKg5), .rst_SP_ENg(rst_SP_ENg), .RFSsm(RFSsm), .DR(DR),
    .SLEN(SLEN), .DTYPE(DTYPE), .MWORD(MWORD), .RBUF(RBUF), .RSack(RSack),
    .RX(RX), .RX_valid(RX_valid), .RSreq(RSreq), .RIRQ(RIRQ), .ROVF(ROVF),
    .SLOT_NUM(SLOT_NUM)
  );

  always #5 SCLKg5 = ~SCLKg5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference formatting: keep SLEN+1 low bits, optionally fill above with the data MSB.
  function automatic logic [15:0] ref_fmt(input logic [15:0] d, input int slen, input logic dt);
    int mask;
    int v;
    mask = (1 << (slen + 1)) - 1;
    v = int'(d) & mask;
    if (dt && (((v >> slen) & 1) == 1)) v = v | (~mask & 32'h0000FFFF);
    return v[15:0];
  endfunction

  function automatic logic pick_ack(input int mode, input logic last);
    case (mode)
      1: return ($urandom_range(0, 3) == 0);
      2: return last;
      default: return 1'b0;
    endcase
  endfunction

  // One rising edge; update the model from the inputs held across it, then compare.
  task automatic do_edge(input logic comp, input logic [15:0] word_exp, input int slot,
                         input logic slot_chk);
    @(posedge SCLKg5);
    #1;
    if (comp) begin
      exp_rx = word_exp;
      if (RBUF) begin
        if (exp_rsreq && !RSack) exp_rovf = 1'b1;
        exp_rsreq = 1'b1;
      end
    end else if (RSack) begin
      exp_rsreq = 1'b0;
    end
    chk("rx_valid", 32'(RX_valid), 32'(comp));
    chk("rirq", 32'(RIRQ), 32'(comp & ~RBUF));
    chk("rsreq", 32'(RSreq), 32'(exp_rsreq));
    chk("rovf", 32'(ROVF), 32'(exp_rovf));
    chk("rx", 32'(RX), 32'(exp_rx));
    if (slot_chk) chk("slot", 32'(SLOT_NUM), 32'(slot & 15));
  endtask

  task automatic idle(input int n, input logic ack);
    for (int c = 0; c < n; c++) begin
      RFSsm = 1'b0;
      RSack = ack;
      do_edge(1'b0, 16'h0000, 0, 1'b0);
    end
    RSack = 1'b0;
  endtask

  // Frame of mword+1 words taken from wbuf; noise toggles RFSsm mid-frame and randomizes guard DR.
  task automatic run_frame(input int slen, input logic dt, input int mword, input logic rb,
                           input int ack_mode, input logic noise);
    logic [15:0] w;
    SLEN  = slen[4:0];
    DTYPE = dt;
    MWORD = mword[7:0];
    RBUF  = rb;
    RFSsm = 1'b1;
    DR    = 1'($urandom);
    RSack = pick_ack(ack_mode, 1'b0);
    do_edge(1'b0, 16'h0000, mword, 1'b1);
    RFSsm = 1'b0;
    for (int k = 0; k <= mword; k++) begin
      w = wbuf[k];
      if (k > 0) begin
        DR    = noise ? 1'($urandom) : 1'b1;
        RFSsm = noise ? 1'($urandom) : 1'b0;
        RSack = pick_ack(ack_mode, 1'b0);
        do_edge(1'b0, 16'h0000, mword - k, 1'b1);
      end
      for (int i = slen; i >= 0; i--) begin
        DR    = w[i];
        RFSsm = noise ? 1'($urandom) : 1'b0;
        RSack = pick_ack(ack_mode, i == 0);
        do_edge(i == 0, ref_fmt(w, slen, dt), mword - k, i != 0);
      end
    end
    RFSsm = 1'b0;
    RSack = 1'b0;
  endtask

  initial begin
    rst_SP_ENg = 1'b1;
    RFSsm = 1'b0; DR = 1'b0; SLEN = 5'd7; DTYPE = 1'b0; MWORD = 8'd0;
    RBUF = 1'b0; RSack = 1'b0;
    exp_rx = 16'h0000; exp_rsreq = 1'b0; exp_rovf = 1'b0;
    #2;
    chk("reset_rx", 32'(RX), 32'h0);
    chk("reset_slot", 32'(SLOT_NUM), 32'h0);
    do_edge(1'b0, 16'h0000, 0, 1'b1);
    rst_SP_ENg = 1'b0;
    idle(2, 1'b0);

    // Single word, zero-fill, interrupt mode: 1,0,1,1,0,0,1,0 -> 0x00B2.
    wbuf[0] = 16'h00B2;
    run_frame(7, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("t1_rx", 32'(RX), 32'h00B2);
    idle(2, 1'b0);

    // Sign-extend: 1010 -> 0xFFFA, 0110 -> 0x0006.
    wbuf[0] = 16'h000A;
    run_frame(3, 1'b1, 0, 1'b0, 0, 1'b0);
    chk("t2_neg", 32'(RX), 32'hFFFA);
    wbuf[0] = 16'h0006;
    run_frame(3, 1'b1, 0, 1'b0, 0, 1'b0);
    chk("t2_pos", 32'(RX), 32'h0006);
    idle(1, 1'b0);

    // Multichannel, three 16-bit words, RFSsm noise mid-frame.
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD; wbuf[2] = 16'h8001;
    run_frame(15, 1'b0, 2, 1'b0, 0, 1'b1);
    chk("t3_last", 32'(RX), 32'h8001);
    idle(2, 1'b0);

    // Autobuffer: request, ack clears, completion with same-edge ack keeps request, no overrun.
    wbuf[0] = 16'h005A;
    run_frame(7, 1'b0, 0, 1'b1, 0, 1'b0);
    idle(1, 1'b1);
    chk("t4_cleared", 32'(RSreq), 32'h0);
    wbuf[0] = 16'h00C3;
    run_frame(7, 1'b0, 0, 1'b1, 0, 1'b0);
    wbuf[0] = 16'h003C;
    run_frame(7, 1'b0, 0, 1'b1, 2, 1'b0);
    chk("t4_req", 32'(RSreq), 32'h1);
    chk("t4_noovf", 32'(ROVF), 32'h0);
    idle(1, 1'b1);

    // Overrun: two words without ack; flag survives a later ack.
    wbuf[0] = 16'h0011; wbuf[1] = 16'h0077;
    run_frame(7, 1'b0, 1, 1'b1, 0, 1'b0);
    chk("t5_rx", 32'(RX), 32'h0077);
    chk("t5_ovf", 32'(ROVF), 32'h1);
    idle(1, 1'b1);
    idle(2, 1'b0);
    chk("t5_sticky", 32'(ROVF), 32'h1);

    // Reset mid-word after 5 of 16 bits, then a clean 0x00FF frame.
    wbuf[0] = 16'h0077;
    SLEN = 5'd15; DTYPE = 1'b0; MWORD = 8'd0; RBUF = 1'b1;
    RFSsm = 1'b1;
    do_edge(1'b0, 16'h0000, 0, 1'b1);
    RFSsm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      DR = 1'b1;
      do_edge(1'b0, 16'h0000, 0, 1'b1);
    end
    rst_SP_ENg = 1'b1;
    #1;
    exp_rx = 16'h0000; exp_rsreq = 1'b0; exp_rovf = 1'b0;
    chk("t6_rx", 32'(RX), 32'h0);
    chk("t6_rsreq", 32'(RSreq), 32'h0);
    chk("t6_rovf", 32'(ROVF), 32'h0);
    chk("t6_valid", 32'(RX_valid), 32'h0);
    do_edge(1'b0, 16'h0000, 0, 1'b1);
    rst_SP_ENg = 1'b0;
    idle(1, 1'b0);
    wbuf[0] = 16'h00FF;
    run_frame(15, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("t6_clean", 32'(RX), 32'h00FF);
    idle(1, 1'b0);

    // Randomized frames: lengths, formats, channel counts, modes, acks and noise.
    for (int f = 0; f < 40; f++) begin
      int slen_r;
      int mw_r;
      slen_r = $urandom_range(2, 15);
      mw_r   = $urandom_range(0, 3);
      for (int k = 0; k < 8; k++) wbuf[k] = 16'($urandom);
      run_frame(slen_r, 1'($urandom), mw_r, 1'($urandom), 1, 1'b1);
      idle($urandom_range(0, 2), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sport1_rx_ctl.md
Name: sport1_rx_ctl

Overview:
- Receive-side control for SPORT1: frames serial data from DR into words and delivers them to the DSP core.
- Runs a 3-state receive machine on SCLKg5 with a bit counter (word length SLEN+1) and a word counter (multichannel windows).
- Deserializes MSB-first data, formats each word as zero-fill or sign-extend, and presents it on RX.
- Raises either a core interrupt or an autobuffer/DMA request, with overrun detection.

Parameters:
WCNT_W, 8, width of word (channel) counter and MWORD field used.

Ports:
SCLKg5  in  1  gated serial clock; all state advances on rising edge.
rst_SP_ENg  in  1  reset, asynchronous, active-high; clock is SCLKg5.
RFSsm  in  1  receive frame sync detected (qualified upstream, SCLKg5 domain).
DR  in  1  serial receive data, sampled on SCLKg5 rising edge.
SLEN  in  5  word length minus one; legal 2..15.
DTYPE  in  1  0 = right-justify zero-fill, 1 = right-justify sign-extend.
MWORD  in  WCNT_W  extra words per frame (0 = single word).
RBUF  in  1  autobuffer mode: 1 = request DMA via RSreq, 0 = interrupt via RIRQ.
RSack  in  1  request acknowledge, synchronous to SCLKg5; clears RSreq.
RX  out  16  last received, formatted word.
RX_valid  out  1  one-cycle pulse: RX updated.
RSreq  out  1  autobuffer service request (level).
RIRQ  out  1  one-cycle receive interrupt pulse (non-autobuffer).
ROVF  out  1  sticky overrun flag.
SLOT_NUM  out  4  Wcnt[3:0], current channel slot.

Behaviour:
- Reset (async, any time): state = IDLE (3'b001). Bcnt = 0, Wcnt = 0, RXSHT = 0, RX = 0x0000. RX_valid, RSreq, RIRQ, ROVF = 0. A partial word in progress is discarded.
- States, one-hot:
  - IDLE = 001, SHIFT = 010, WSTART = 100. Illegal encodings go to IDLE on the next edge.
  - IDLE -> SHIFT when RFSsm = 1; else stay.
  - SHIFT -> SHIFT while Bcnt != 0.
  - SHIFT with Bcnt == 0 -> IDLE if Wcnt == 0, else WSTART.
  - WSTART -> SHIFT unconditionally. WSTART is a one-cycle guard slot; DR is not sampled.
- Entry edge into SHIFT (from IDLE or WSTART): Bcnt <= SLEN, RXSHT <= 0. No DR sample on this edge.
- Each edge while in SHIFT:
  - RXSHT <= {RXSHT[14:0], DR}.
  - If Bcnt != 0: Bcnt <= Bcnt - 1.
  - If Bcnt == 0: this edge samples the last bit. A word is therefore exactly SLEN+1 samples, MSB first.
- Word counter:
  - Wcnt <= MWORD on the IDLE -> SHIFT edge.
  - Wcnt <= Wcnt - 1 on the SHIFT -> WSTART edge.
  - SLOT_NUM = Wcnt[3:0], combinational.
- Word completion (SHIFT edge with Bcnt == 0):
  - Raw word W = {RXSHT[14:0], DR}. W[SLEN:0] holds the data; bits above SLEN are 0 because RXSHT was cleared on entry.
  - RX <= W if DTYPE = 0.
  - RX <= W with bits [15:SLEN+1] = W[SLEN] if DTYPE = 1.
  - RX and RX_valid update on that same edge; RX_valid is high for exactly the following cycle. Latency is 0 edges from the last-bit sample.
- Request and interrupt, on completion:
  - If RBUF = 1: RSreq <= 1. If RBUF = 0: RIRQ pulses one cycle, coincident with RX_valid.
  - RSreq clears on an edge with RSack = 1 and no completion.
  - Completion and RSack on the same edge: RSreq stays 1 (set wins).
- Overrun: a completion with RBUF = 1 while RSreq is already 1 (and no RSack that edge) sets ROVF. RX is still overwritten. ROVF clears only on reset.
- RFSsm in SHIFT or WSTART is ignored (no resync mid-frame).
- SLEN and DTYPE are sampled live. They must be stable from the SHIFT entry edge through word completion; a change mid-word is undefined.
- SLEN < 2: behaviour follows the counter rules above with no protection; not a supported configuration.

Test Plan:
1. Single word, zero-fill. SLEN=7, DTYPE=0, MWORD=0, RBUF=0. Pulse RFSsm; DR = 1,0,1,1,0,0,1,0 on the 8 SHIFT edges -> RX=0x00B2, RX_valid and RIRQ high one cycle, state IDLE on the next edge, RSreq=0.
2. Sign-extend. SLEN=3, DTYPE=1; DR = 1,0,1,0 -> RX=0xFFFA. Repeat with DR = 0,1,1,0 -> RX=0x0006.
3. Multichannel. SLEN=15, MWORD=2; words 0x1234, 0xABCD, 0x8001, with one WSTART cycle (DR=1, ignored) between words -> three RX_valid pulses with those values, SLOT_NUM 2,1,0 during the respective words, IDLE after the third; RFSsm asserted mid-word has no effect.
4. Autobuffer handshake. RBUF=1, SLEN=7, word 0x5A -> RSreq=1, no RIRQ. RSack one cycle -> RSreq=0. Second word with RSack on its completion edge -> RSreq stays 1, ROVF=0.
5. Overrun. RBUF=1; receive two words without RSack -> second RX value visible, ROVF=1 and stays 1 after a later RSack; clears only on rst_SP_ENg.
6. Reset mid-word. Assert rst_SP_ENg after 5 of 16 bits -> all outputs 0 immediately (async). After release, a new RFSsm frame of 0x00FF (SLEN=15) -> RX=0x00FF with no residue from the aborted word.
